aes_block_loader: RTL and testbench

- Byte-serial front end that sits directly upstream of the AES core.
- Collects 16 plaintext bytes, then 4*nk key bytes, over a valid/ready byte interface, and presents them as stable parallel Message and Key buses.
- Pulses core_start, then counts out the core's fixed run latency before returning to idle.
- Message and Key stay frozen while the core runs.

---
 rtl/aes_block_loader_if.sv | 33 +++
 rtl/aes_block_loader.sv | 136 +++++++++++++
 tb/tb_aes_block_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_loader_if.sv
// ============================================================================
// Module      : aes_block_loader_if
// Description : Byte-stream handshake and parallel Message/Key buses between
//               a byte source and the AES block loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_block_loader_if #(
  parameter int NK = 4
);
  logic [7:0]         in_byte;
  logic               in_valid;
  logic               in_ready;
  logic               abort;
  logic [0:127]       Message;
  logic [0:32*NK-1]   Key;
  logic               core_start;
  logic               busy;
  logic               run_done;

  modport master (
    output in_byte, in_valid, abort,
    input  in_ready, Message, Key, core_start, busy, run_done
  );

  modport slave (
    input  in_byte, in_valid, abort,
    output in_ready, Message, Key, core_start, busy, run_done
  );
endinterface

`default_nettype wire

// File: rtl/aes_block_loader.sv
// ============================================================================
// Module      : aes_block_loader
// Description : Collects 16 message bytes and 4*NK key bytes, starts the AES
//               core and times its fixed run latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_block_loader #(
  parameter int NK         = 4,
  parameter int NR         = 10,
  parameter int RUN_CYCLES = 2*NR+2
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_block_loader_if.slave  bus
);

  localparam int         c_KEY_BITS = 32*NK;
  localparam int         c_KEY_IW   = $clog2(c_KEY_BITS);
  localparam int         c_RUN_W    = ($clog2(RUN_CYCLES) < 5) ? 5 : $clog2(RUN_CYCLES);
  localparam logic [5:0] c_MSG_LAST = 6'd15;
  localparam logic [5:0] c_KEY_LAST = 6'(4*NK-1);
  localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(RUN_CYCLES-1);

  typedef enum logic [1:0] {
    LOAD_MSG = 2'd0,
    LOAD_KEY = 2'd1,
    START    = 2'd2,
    RUN      = 2'd3
  } state_t;

  state_t               r_state;
  logic [5:0]           r_cnt;
  logic [c_RUN_W-1:0]   r_run_cnt;
  logic [0:127]         r_msg;
  logic [0:c_KEY_BITS-1] r_key;
  logic                 r_in_ready;
  logic                 r_core_start;
  logic                 r_busy;
  logic                 r_run_done;

  logic                 w_accept;
  logic [6:0]           w_msg_idx;
  logic [c_KEY_IW-1:0]  w_key_idx;

  // in_ready is a register, so acceptance never loops back through in_valid
  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_msg_idx = 7'({r_cnt, 3'b000});
  assign w_key_idx = c_KEY_IW'({r_cnt, 3'b000});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= LOAD_MSG;
      r_cnt        <= '0;
      r_run_cnt    <= '0;
      r_msg        <= '0;
      r_key        <= '0;
      r_in_ready   <= 1'b1;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_run_done   <= 1'b0;
    end else if (bus.abort) begin
      // Buses keep their contents; only the sequence restarts
      r_state      <= LOAD_MSG;
      r_cnt        <= '0;
      r_run_cnt    <= '0;
      r_in_ready   <= 1'b1;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_run_done   <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_run_done   <= 1'b0;
      case (r_state)
        LOAD_MSG: begin
          if (w_accept) begin
            r_msg[w_msg_idx +: 8] <= bus.in_byte;
            if (r_cnt == c_MSG_LAST) begin
              r_cnt   <= '0;
              r_state <= LOAD_KEY;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        LOAD_KEY: begin
          if (w_accept) begin
            r_key[w_key_idx +: 8] <= bus.in_byte;
            if (r_cnt == c_KEY_LAST) begin
              r_cnt        <= '0;
              r_state      <= START;
              r_in_ready   <= 1'b0;
              r_core_start <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        START: begin
          r_state    <= RUN;
          r_run_cnt  <= '0;
          r_busy     <= 1'b1;
          r_run_done <= (c_RUN_LAST == '0);
        end
        RUN: begin
          // run_done is raised together with the final count value so it
          // lines up with the last busy cycle
          if (r_run_cnt == c_RUN_LAST) begin
            r_state    <= LOAD_MSG;
            r_run_cnt  <= '0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end else begin
            r_run_cnt  <= r_run_cnt + c_RUN_W'(1);
            r_run_done <= ((r_run_cnt + c_RUN_W'(1)) == c_RUN_LAST);
          end
        end
        default: begin
          r_state    <= LOAD_MSG;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.Message    = r_msg;
  assign bus.Key        = r_key;
  assign bus.core_start = r_core_start;
  assign bus.busy       = r_busy;
  assign bus.run_done   = r_run_done;

endmodule

`default_nettype wire

// File: tb/tb_aes_block_loader.sv
// ============================================================================
// Module      : tb_aes_block_loader
// Description : Self-checking bench for aes_block_loader in AES-128 and AES-256
//               configurations against a byte-count/latency reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_block_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_block_loader_if #(.NK(4)) if4 ();
  aes_block_loader_if #(.NK(8)) if8 ();

  aes_block_loader #(.NK(4), .NR(10)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  aes_block_loader #(.NK(8), .NR(14)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  int checks = 0;
  int errors = 0;

  // Reference model: bytes taken in the current block and cycles since the
  // last key byte was taken (0 = loading, 1 = start cycle, 2.. = running).
  int         c_KBYTES [2] = '{16, 32};
  int         c_RUNC   [2] = '{22, 30};
  int         got   [2];
  int         since [2];
  logic [7:0] mb [2][16];
  logic [7:0] kb [2][32];
  int         cs_cnt [2];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_msg(input int d);
    logic [255:0] r = '0;
    for (int i = 0; i < 16; i++) r = (r << 8) | 256'(mb[d][i]);
    return r;
  endfunction

  function automatic logic [255:0] exp_key(input int d);
    logic [255:0] r = '0;
    for (int i = 0; i < c_KBYTES[d]; i++) r = (r << 8) | 256'(kb[d][i]);
    return r;
  endfunction

  task automatic model_step(input int d, input logic v, input logic [7:0] b, input logic ab);
    if (!rst_n) begin
      got[d] = 0; since[d] = 0;
      for (int i = 0; i < 16; i++) mb[d][i] = 8'h00;
      for (int i = 0; i < 32; i++) kb[d][i] = 8'h00;
    end else if (ab) begin
      got[d] = 0; since[d] = 0;
    end else if (since[d] > 0) begin
      since[d] = (since[d] == c_RUNC[d] + 1) ? 0 : since[d] + 1;
    end else if (v) begin
      if (got[d] < 16) mb[d][got[d]] = b;
      else             kb[d][got[d]-16] = b;
      got[d]++;
      if (got[d] == 16 + c_KBYTES[d]) begin
        got[d] = 0; since[d] = 1;
      end
    end
  endtask

  function automatic logic rdy(input int d);  return d ? if8.in_ready   : if4.in_ready;   endfunction
  function automatic logic cst(input int d);  return d ? if8.core_start : if4.core_start; endfunction
  function automatic logic bsy(input int d);  return d ? if8.busy       : if4.busy;       endfunction
  function automatic logic dn(input int d);   return d ? if8.run_done   : if4.run_done;   endfunction
  function automatic logic [255:0] msg(input int d); return d ? 256'(if8.Message) : 256'(if4.Message); endfunction
  function automatic logic [255:0] key(input int d); return d ? 256'(if8.Key) : 256'(if4.Key); endfunction

  task automatic check_dut(input int d);
    chk($sformatf("d%0d_in_ready", d),   256'(rdy(d)), 256'(since[d] == 0));
    chk($sformatf("d%0d_core_start", d), 256'(cst(d)), 256'(since[d] == 1));
    chk($sformatf("d%0d_busy", d),       256'(bsy(d)), 256'(since[d] >= 2));
    chk($sformatf("d%0d_run_done", d),   256'(dn(d)),  256'(since[d] == c_RUNC[d] + 1));
    chk($sformatf("d%0d_message", d),    msg(d), exp_msg(d));
    chk($sformatf("d%0d_key", d),        key(d), exp_key(d));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, if4.in_valid, if4.in_byte, if4.abort);
    model_step(1, if8.in_valid, if8.in_byte, if8.abort);
    #1;
    check_dut(0);
    check_dut(1);
    if (if4.core_start) cs_cnt[0]++;
    if (if8.core_start) cs_cnt[1]++;
  endtask

  task automatic set_in(input int d, input logic v, input logic [7:0] b, input logic ab);
    if (d == 0) begin if4.in_valid = v; if4.in_byte = b; if4.abort = ab; end
    else        begin if8.in_valid = v; if8.in_byte = b; if8.abort = ab; end
  endtask

  // Offer one byte until it is taken; gap inserts random idle cycles first
  task automatic send(input int d, input logic [7:0] b, input bit gap);
    logic acc;
    int   n = 0;
    if (gap) repeat ($urandom_range(0, 2)) tick();
    set_in(d, 1'b1, b, 1'b0);
    do begin
      acc = rdy(d);
      tick();
      n++;
    end while (!acc && n < 64);
    if (!acc) chk($sformatf("d%0d_send_timeout", d), 256'(acc), 256'(1));
    set_in(d, 1'b0, 8'h00, 1'b0);
  endtask

  // Tick until run_done is seen; returns cycles taken and busy cycles seen
  task automatic run_out(input int d, output int n, output int nbusy, output int nrdy);
    n = 0; nbusy = 0; nrdy = 0;
    do begin
      tick();
      n++;
      if (bsy(d)) nbusy++;
      if (rdy(d)) nrdy++;
    end while (!dn(d) && n < 200);
    chk($sformatf("d%0d_run_done_seen", d), 256'(dn(d)), 256'(1));
    tick();
  endtask

  task automatic send_block(input int d, input bit gap);
    for (int i = 0; i < 16 + c_KBYTES[d]; i++) send(d, 8'($urandom), gap);
  endtask

  logic [255:0] c_KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic [255:0] snap_m, snap_k;
  logic [7:0]   b0;
  int n, nb, nr, cs0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      set_in(d, 1'b0, 8'h00, 1'b0);
      got[d] = 0; since[d] = 0; cs_cnt[d] = 0;
    end
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_message", msg(0), 256'h0);
    chk("reset_in_ready", 256'(rdy(1)), 256'(1));

    // AES-128 known block, in_valid held high
    for (int i = 0; i < 16; i++) send(0, 8'(i * 17), 1'b0);
    for (int i = 0; i < 16; i++) send(0, 8'(i), 1'b0);
    chk("s1_core_start_next", 256'(cst(0)), 256'(1));
    run_out(0, n, nb, nr);
    chk("s1_run_done_latency", 256'(n), 256'(22));
    chk("s1_in_ready_low", 256'(nr), 256'(0));
    chk("s1_message", msg(0), 256'h00112233445566778899aabbccddeeff);
    chk("s1_key", key(0), 256'h000102030405060708090a0b0c0d0e0f);

    // AES-256 known key
    cs0 = cs_cnt[1];
    for (int i = 0; i < 16; i++) send(1, 8'(i * 17), 1'b0);
    for (int i = 0; i < 31; i++) send(1, c_KEY256[255 - 8*i -: 8], 1'b0);
    chk("s2_no_early_start", 256'(cs_cnt[1] - cs0), 256'(0));
    send(1, c_KEY256[7:0], 1'b0);
    chk("s2_core_start_after_48", 256'(cst(1)), 256'(1));
    run_out(1, n, nb, nr);
    chk("s2_busy_cycles", 256'(nb), 256'(30));
    chk("s2_key", key(1), c_KEY256);

    // Random data, then the known block, with random in_valid gaps
    cs0 = cs_cnt[0];
    send_block(0, 1'b1);
    run_out(0, n, nb, nr);
    for (int i = 0; i < 16; i++) send(0, 8'(i * 17), 1'b1);
    for (int i = 0; i < 16; i++) send(0, 8'(i), 1'b1);
    run_out(0, n, nb, nr);
    chk("s3_start_count", 256'(cs_cnt[0] - cs0), 256'(2));
    chk("s3_message", msg(0), 256'h00112233445566778899aabbccddeeff);
    chk("s3_key", key(0), 256'h000102030405060708090a0b0c0d0e0f);

    // Bytes offered throughout RUN are dropped
    send_block(0, 1'b0);
    snap_m = msg(0); snap_k = key(0);
    n = 0;
    while (!dn(0) && n < 200) begin
      set_in(0, 1'b1, 8'($urandom), 1'b0);
      tick();
      n++;
    end
    set_in(0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("s4_message_frozen", msg(0), snap_m);
    chk("s4_key_frozen", key(0), snap_k);
    b0 = 8'($urandom);
    send(0, b0, 1'b0);
    chk("s4_first_byte_slot", 256'(if4.Message[0:7]), 256'(b0));
    for (int i = 1; i < 32; i++) send(0, 8'($urandom), 1'b0);
    run_out(0, n, nb, nr);

    // abort after 7 message bytes, with a byte offered alongside it
    cs0 = cs_cnt[0];
    for (int i = 0; i < 7; i++) send(0, 8'($urandom), 1'b0);
    set_in(0, 1'b1, 8'hA5, 1'b1);
    tick();
    set_in(0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 31; i++) send(0, 8'($urandom), 1'b0);
    chk("s5_no_start_before_32", 256'(cs_cnt[0] - cs0), 256'(0));
    send(0, 8'($urandom), 1'b0);
    chk("s5_start_after_32", 256'(cst(0)), 256'(1));
    run_out(0, n, nb, nr);

    // Reset in the middle of RUN
    send_block(0, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s6_busy_cleared", 256'(bsy(0)), 256'(0));
    chk("s6_in_ready", 256'(rdy(0)), 256'(1));
    chk("s6_message_zero", msg(0), 256'h0);
    chk("s6_key_zero", key(0), 256'h0);
    nr = 0;
    repeat (30) begin
      tick();
      if (dn(0)) nr++;
    end
    chk("s6_no_run_done", 256'(nr), 256'(0));
    cs0 = cs_cnt[0];
    send_block(0, 1'b1);
    run_out(0, n, nb, nr);
    chk("s6_reload_start", 256'(cs_cnt[0] - cs0), 256'(1));
    chk("s6_reload_latency", 256'(n), 256'(22));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
